stft_framer: RTL and testbench



---
 rtl/stft_framer.sv | 192 +++++++++++++++++++
 tb/tb_stft_framer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stft_framer.sv
// Streaming STFT framer: circular sample buffer, windowing with a loadable
// coefficient RAM, zero padding to N_FFT, and a two-stage stallable output pipe.
module stft_framer #(
    parameter int WIDTH     = 16,
    parameter int COE_WIDTH = 16,
    parameter int N_FFT     = 512,
    parameter int WIN_LEN   = 480,
    parameter int HOP_LEN   = 160,
    localparam int BUF_DEPTH = 2 ** $clog2(WIN_LEN),
    localparam int AW        = $clog2(BUF_DEPTH),
    localparam int IW        = $clog2(N_FFT),
    localparam int CAW       = $clog2(WIN_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] m_data,
    output logic [IW-1:0]           m_idx,
    output logic                    m_last,
    input  logic                    coe_we,
    input  logic [CAW-1:0]          coe_addr,
    input  logic [COE_WIDTH-1:0]    coe_data,
    input  logic                    win_bypass,
    output logic [15:0]             frame_cnt,
    output logic                    dbg_state
);

    // Handshakes: a beat moves on a rising edge where valid && ready are both high;
    // a producer holding valid keeps its payload stable until that edge.

    localparam int PW = WIDTH + COE_WIDTH + 1;
    localparam logic signed [PW-1:0] RND_HALF = PW'(2 ** (COE_WIDTH - 2));
    localparam logic signed [PW-1:0] SAT_MAX  = PW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [PW-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t r_state, w_state_nxt;

    logic signed [WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [COE_WIDTH-1:0]    r_coe [WIN_LEN];

    logic [AW-1:0] r_wr_ptr, r_rd_base;
    logic [AW:0]   r_fill, w_fill_nxt;
    logic [IW-1:0] r_idx;
    logic          r_byp;

    logic          w_adv, w_wr, w_issue, w_frame_done, w_pad;
    logic [AW-1:0] w_rd_addr;

    logic                    r_s1_valid, r_s1_last, r_s1_pad, r_s1_byp;
    logic [IW-1:0]           r_s1_idx;
    logic signed [WIDTH-1:0] r_s1_sample;
    logic [COE_WIDTH-1:0]    r_s1_coe;

    logic signed [PW-1:0]    w_s_ext, w_c_ext, w_prod, w_rnd, w_shr;
    logic signed [WIDTH-1:0] w_res;

    logic                    r_m_valid, r_m_last;
    logic signed [WIDTH-1:0] r_m_data;
    logic [IW-1:0]           r_m_idx;
    logic [15:0]             r_frame_cnt;

    assign s_ready   = !rst && (r_fill < (AW+1)'(BUF_DEPTH));
    assign w_wr      = s_valid && s_ready;
    assign w_adv     = !r_m_valid || m_ready;
    assign w_pad     = int'(r_idx) >= WIN_LEN;
    assign w_rd_addr = r_rd_base + AW'(r_idx);

    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_idx     = r_m_idx;
    assign m_last    = r_m_last;
    assign frame_cnt = r_frame_cnt;
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (int'(r_fill) >= WIN_LEN) w_state_nxt = EMIT;
            EMIT: if (w_frame_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_issue      = (r_state == EMIT) && w_adv;
        w_frame_done = w_issue && (r_idx == IW'(N_FFT - 1));
    end

    always_comb begin
        w_fill_nxt = r_fill;
        if (w_wr)         w_fill_nxt = w_fill_nxt + 1'b1;
        if (w_frame_done) w_fill_nxt = w_fill_nxt - (AW+1)'(HOP_LEN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_base <= '0;
            r_fill    <= '0;
            r_idx     <= '0;
            r_byp     <= 1'b0;
        end else begin
            r_fill <= w_fill_nxt;
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_state == IDLE) begin
                r_idx <= '0;
                // Bypass is sampled once so a frame is never half windowed.
                if (w_state_nxt == EMIT) r_byp <= win_bypass;
            end else if (w_issue) begin
                if (w_frame_done) begin
                    r_idx     <= '0;
                    r_rd_base <= r_rd_base + AW'(HOP_LEN);
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // Memories carry no reset; reads only fire for real, unpadded issues.
    always_ff @(posedge clk) begin
        if (w_wr) r_buf[r_wr_ptr] <= s_data;
        if (w_issue && !w_pad) r_s1_sample <= r_buf[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (coe_we && (int'(coe_addr) < WIN_LEN)) r_coe[coe_addr] <= coe_data;
        if (w_issue && !w_pad) r_s1_coe <= r_coe[CAW'(r_idx)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_pad   <= 1'b0;
            r_s1_byp   <= 1'b0;
            r_s1_idx   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_issue;
            r_s1_last  <= w_frame_done;
            r_s1_pad   <= w_pad;
            r_s1_byp   <= r_byp;
            r_s1_idx   <= r_idx;
        end
    end

    // Coefficient is unsigned, so it is zero extended before the signed multiply.
    always_comb begin
        w_s_ext = PW'(r_s1_sample);
        w_c_ext = PW'({1'b0, r_s1_coe});
        w_prod  = w_s_ext * w_c_ext;
        w_rnd   = w_prod + RND_HALF;
        w_shr   = w_rnd >>> (COE_WIDTH - 1);
        if (r_s1_pad)           w_res = '0;
        else if (r_s1_byp)      w_res = r_s1_sample;
        else if (w_shr > SAT_MAX) w_res = WIDTH'(SAT_MAX);
        else if (w_shr < SAT_MIN) w_res = WIDTH'(SAT_MIN);
        else                    w_res = WIDTH'(w_shr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_idx     <= '0;
            r_m_last    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_adv) begin
                r_m_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_m_data <= w_res;
                    r_m_idx  <= r_s1_idx;
                    r_m_last <= r_s1_last;
                end
            end
            if (r_m_valid && m_ready && r_m_last) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_stft_framer.sv
// Bench for stft_framer: stream drivers, a frame-level golden model feeding an
// expected queue, and a monitor that pops and compares every output beat.
module tb_stft_framer;

    localparam int WIDTH     = 16;
    localparam int COE_WIDTH = 16;
    localparam int N_FFT     = 512;
    localparam int WIN_LEN   = 480;
    localparam int HOP_LEN   = 160;
    localparam int IW        = 9;
    localparam int CAW       = 9;
    localparam int EW        = 1 + IW + WIDTH;

    logic                    clk, rst;
    logic                    s_valid, s_ready;
    logic signed [WIDTH-1:0] s_data;
    logic                    m_valid, m_ready, m_last;
    logic signed [WIDTH-1:0] m_data;
    logic [IW-1:0]           m_idx;
    logic                    coe_we;
    logic [CAW-1:0]          coe_addr;
    logic [COE_WIDTH-1:0]    coe_data;
    logic                    win_bypass;
    logic [15:0]             frame_cnt;
    logic                    dbg_state;

    stft_framer dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_idx(m_idx), .m_last(m_last),
        .coe_we(coe_we), .coe_addr(coe_addr), .coe_data(coe_data),
        .win_bypass(win_bypass), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp_v);
        n_checks++;
        if (got == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
    endtask

    // Model state
    logic [EW-1:0]           exp_q[$];
    logic signed [WIDTH-1:0] in_hist[$];
    logic [COE_WIDTH-1:0]    coe_m [WIN_LEN];
    logic signed [WIDTH-1:0] rnd_tab [4096];
    logic signed [WIDTH-1:0] arith_s [5];
    logic signed [WIDTH-1:0] cap [4][N_FFT];
    logic                    cfg_byp;
    int pat, in_mode, out_mode, in_limit;
    int next_frame, frames_done, idle_cnt, cyc, first_acc_cyc, first_mv_cyc;
    logic          prev_stall;
    logic [EW-1:0] prev_out;

    function automatic logic signed [WIDTH-1:0] sample_for(input int n);
        if (pat == 0)      return WIDTH'(n);
        else if (pat == 1) return rnd_tab[n % 4096];
        else if (n < 5)    return arith_s[n];
        else               return rnd_tab[n % 4096];
    endfunction

    function automatic logic signed [WIDTH-1:0] ref_win(input logic signed [WIDTH-1:0] s,
                                                        input logic [COE_WIDTH-1:0] c);
        longint p, q, one, maxv;
        one  = longint'(1) << (COE_WIDTH - 1);
        maxv = (longint'(1) << (WIDTH - 1)) - 1;
        p = longint'(s) * longint'(c);
        q = p + (one / 2);
        if (q >= 0) q = q / one;
        else         q = -((-q + one - 1) / one);
        if (q > maxv)      q = maxv;
        if (q < -maxv - 1) q = -maxv - 1;
        return WIDTH'(q);
    endfunction

    function automatic void push_frame(input int f);
        logic signed [WIDTH-1:0] v;
        for (int i = 0; i < N_FFT; i++) begin
            if (i >= WIN_LEN) v = '0;
            else if (cfg_byp) v = in_hist[f * HOP_LEN + i];
            else              v = ref_win(in_hist[f * HOP_LEN + i], coe_m[i]);
            exp_q.push_back({(i == N_FFT - 1), IW'(i), v});
        end
    endfunction

    function automatic void flush_model();
        exp_q.delete();
        in_hist.delete();
        next_frame    = 0;
        frames_done   = 0;
        idle_cnt      = 0;
        first_acc_cyc = -1;
        first_mv_cyc  = -1;
        prev_stall    = 1'b0;
    endfunction

    // Input / output-ready driver
    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (in_mode != 0 && in_hist.size() < in_limit)
                s_valid = (in_mode == 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
            else
                s_valid = 1'b0;
            s_data = sample_for(in_hist.size());
            if (out_mode == 1)      m_ready = 1'b1;
            else if (out_mode == 2) m_ready = ($urandom_range(0, 1) == 1);
            else                    m_ready = 1'b0;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [EW-1:0] obs, e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                obs = {m_last, m_idx, m_data};
                if (s_valid && s_ready) begin
                    if (in_hist.size() == 0) first_acc_cyc = cyc;
                    in_hist.push_back(s_data);
                    if (in_hist.size() == next_frame * HOP_LEN + WIN_LEN) begin
                        push_frame(next_frame);
                        next_frame++;
                    end
                end
                if (prev_stall) begin
                    check("stall_valid", m_valid, 1);
                    check("stall_hold", obs, prev_out);
                end
                if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
                if (!m_valid) idle_cnt++;
                if (m_valid && m_ready) begin
                    if (m_idx == 0 && frames_done > 0) check("frame_gap", idle_cnt > 0, 1);
                    if (exp_q.size() == 0) begin
                        check("extra_out", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("out", obs, e);
                    end
                    if (frames_done < 4) cap[frames_done][m_idx] = m_data;
                    if (m_last) begin
                        frames_done++;
                        idle_cnt = 0;
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_out   = obs;
            end
        end
    end

    task automatic do_reset();
        in_mode = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_coe(input int kind);
        logic [COE_WIDTH-1:0] v;
        for (int k = 0; k < WIN_LEN; k++) begin
            @(posedge clk);
            #1;
            if (kind == 0)      v = 16'd32768;
            else if (kind == 1) v = '0;
            else if (k < 2)     v = 16'd32768;
            else if (k < 5)     v = 16'd16384;
            else                v = COE_WIDTH'($urandom_range(0, 65535));
            coe_we   = 1'b1;
            coe_addr = CAW'(k);
            coe_data = v;
            coe_m[k] = v;
        end
        @(posedge clk);
        #1;
        coe_we = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        while ((in_hist.size() < in_limit || exp_q.size() != 0 || m_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (30) @(negedge clk);
        check({tag, "_inputs"}, in_hist.size(), in_limit);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_frame_cnt"}, frame_cnt, frames_done);
        in_mode = 0;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 4096; i++) rnd_tab[i] = WIDTH'($urandom_range(0, 65535));
        arith_s[0] = 16'sh8000;
        arith_s[1] = 16'sh7fff;
        arith_s[2] = 16'sd1;
        arith_s[3] = -16'sd1;
        arith_s[4] = 16'sd3;
        cyc = 0; pat = 0; in_mode = 0; out_mode = 1; in_limit = 0;
        cfg_byp = 1'b0; win_bypass = 1'b0;
        coe_we = 1'b0; coe_addr = '0; coe_data = '0;
        flush_model();
        rst = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_idx", m_idx, 0);
        check("rst_m_last", m_last, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);

        // Unity window on a ramp
        load_coe(0);
        pat = 0; in_limit = 1000; out_mode = 1; in_mode = 1;
        wait_drain("ramp", 6000);
        check("ramp_frames", frames_done, 4);
        check("ramp_latency", first_mv_cyc - first_acc_cyc, 483);
        check("ramp_f0_i0", cap[0][0], 0);
        check("ramp_f0_i479", cap[0][479], 479);
        check("ramp_f0_i480", cap[0][480], 0);
        check("ramp_f1_i0", cap[1][0], 160);
        check("ramp_f1_i479", cap[1][479], 639);
        check("ramp_f2_i0", cap[2][0], 320);

        // Rectangular bypass with zero coefficients
        do_reset();
        load_coe(1);
        cfg_byp = 1'b1; win_bypass = 1'b1;
        pat = 1; in_limit = 800; out_mode = 1; in_mode = 1;
        wait_drain("bypass", 6000);
        check("bypass_frames", frames_done, 3);
        cfg_byp = 1'b0; win_bypass = 1'b0;

        // Rounding/saturation corners, random traffic on both sides
        do_reset();
        load_coe(2);
        pat = 2; in_limit = 1200; out_mode = 2; in_mode = 2;
        wait_drain("arith", 20000);
        check("arith_frames", frames_done, 5);
        check("arith_neg_full", cap[0][0], -32768);
        check("arith_pos_full", cap[0][1], 32767);
        check("arith_half_1", cap[0][2], 1);
        check("arith_half_m1", cap[0][3], 0);
        check("arith_half_3", cap[0][4], 2);

        // Long output stall with continuous input
        do_reset();
        load_coe(0);
        pat = 0; in_limit = 1000; out_mode = 0; in_mode = 1;
        repeat (2000) @(negedge clk);
        check("bp_accepted", in_hist.size(), 512);
        check("bp_s_ready", s_ready, 0);
        out_mode = 1;
        wait_drain("bp", 6000);
        check("bp_f0_i0", cap[0][0], 0);
        check("bp_f0_i479", cap[0][479], 479);

        // Reset in the middle of frame 1
        do_reset();
        pat = 0; in_limit = 5000; out_mode = 1; in_mode = 1;
        found = 1'b0;
        for (int k = 0; k < 4000 && !found; k++) begin
            @(negedge clk);
            if (m_valid && m_idx == 100 && frames_done == 1) found = 1'b1;
        end
        check("midrst_reached", found, 1);
        #1;
        rst = 1'b1;
        in_mode = 0;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_data", m_data, 0);
        check("midrst_m_idx", m_idx, 0);
        check("midrst_m_last", m_last, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_s_ready", s_ready, 0);
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        in_limit = 640; in_mode = 1;
        wait_drain("midrst", 6000);
        check("midrst_frames", frames_done, 2);
        check("midrst_f0_i0", cap[0][0], 0);
        check("midrst_f0_i479", cap[0][479], 479);
        check("midrst_f1_i0", cap[1][0], 160);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
